// File: rtl/s2p_fifo.sv
// Serial-to-parallel converter: assembles N-bit words LSB-first from a bit stream
// and queues completed words in a DEPTH-entry FIFO with valid/ready on both sides.
module s2p_fifo #(
  parameter int N     = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  input  logic                         s_data,
  output logic                         s_ready,
  output logic                         p_valid,
  output logic [N-1:0]                 p_data,
  input  logic                         p_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [N-1:0]  mem_q [DEPTH];
  logic [N-1:0]  mem_d [DEPTH];

  logic beat;
  logic push;
  logic pop;

  // s_ready only blocks the final bit of a word, and only while the buffer is full.
  assign s_ready = (cnt_q != CNT_MAX) || (level_q < DEPTH_L);
  assign p_valid = (level_q != '0);
  assign p_data  = mem_q[rd_ptr_q];
  assign level   = level_q;

  assign beat = s_valid && s_ready;
  assign push = beat && (cnt_q == CNT_MAX);
  assign pop  = p_valid && p_ready;

  always_comb begin
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end

    if (beat) begin
      cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      shift_d = {s_data, shift_q[N-1:1]};
    end

    if (push) begin
      mem_d[wr_ptr_q] = {s_data, shift_q[N-1:1]};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule
